// File: rtl/ifetch_ctrl.sv
// Instruction fetch/sequencing controller for the HRM CPU: fetches opcode and operand at PC,
// hands the instruction to execute, and drives the PC strobes. Optional feature: ILLEGAL_TRAP_EN.
module ifetch_ctrl #(
    parameter int         MEM_LAT  = 1,
    parameter logic [7:0] HALT_OPC = 8'hF0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] memData,
    input  logic       execDone,
    output logic       memRd,
    output logic [7:0] IR,
    output logic [7:0] jmpAddr,
    output logic       execStart,
    output logic       wPC,
    output logic       branch,
    output logic       ijump,
    output logic       halted,
    output logic       illegal
);
    typedef enum logic [2:0] {
        FETCH_OP, WAIT_OP, FETCH_ARG, WAIT_ARG, EXEC, WAIT_EX, HALT
    } state_t;

    localparam logic [1:0] LAT_CNT = 2'(MEM_LAT);

    state_t     state_q;
    logic [1:0] cnt_q;
    logic [7:0] ir_q;
    logic [7:0] jmp_q;
    logic       mem_rd_q;
    logic       exec_start_q;
    logic       wpc_q;
    logic       branch_q;
    logic       ijump_q;
    logic       halted_q;
    logic       data_ready_s;

    function automatic logic needs_operand(input logic [7:0] op);
        return (op[7:4] >= 4'h2) && (op[7:4] <= 4'hA);
    endfunction

    function automatic logic is_jump(input logic [7:0] op);
        return (op[7:4] >= 4'h8) && (op[7:4] <= 4'hA);
    endfunction

    function automatic logic is_ijump(input logic [7:0] op);
        return op[7:4] == 4'h8;
    endfunction

    // Anything outside the defined map that is not the exact halt byte.
    function automatic logic is_illegal(input logic [7:0] op);
        return (op[7:4] >= 4'hB) && (op != HALT_OPC);
    endfunction

    assign data_ready_s = (cnt_q == LAT_CNT);

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // Sequencer state, operand registers and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH_OP;
            cnt_q        <= 2'd0;
            ir_q         <= 8'h00;
            jmp_q        <= 8'h00;
            mem_rd_q     <= 1'b0;
            exec_start_q <= 1'b0;
            wpc_q        <= 1'b0;
            branch_q     <= 1'b0;
            ijump_q      <= 1'b0;
            halted_q     <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q    <= 1'b0;
`endif
        end else begin
            mem_rd_q     <= 1'b0;
            exec_start_q <= 1'b0;
            wpc_q        <= 1'b0;
            branch_q     <= 1'b0;
            ijump_q      <= 1'b0;
            case (state_q)
                FETCH_OP: begin
                    mem_rd_q <= 1'b1;
                    cnt_q    <= 2'd0;
                    state_q  <= WAIT_OP;
                end
                WAIT_OP: begin
                    if (!data_ready_s) begin
                        cnt_q <= cnt_q + 2'd1;
                    end else begin
                        ir_q <= memData;
                        if (memData == HALT_OPC) begin
                            halted_q <= 1'b1;
                            state_q  <= HALT;
                        end else if (needs_operand(memData)) begin
                            wpc_q   <= 1'b1;
                            state_q <= FETCH_ARG;
                        end else if (is_illegal(memData)) begin
`ifdef ILLEGAL_TRAP_EN
                            halted_q  <= 1'b1;
                            illegal_q <= 1'b1;
                            state_q   <= HALT;
`else
                            wpc_q   <= 1'b1;
                            state_q <= FETCH_OP;
`endif
                        end else begin
                            exec_start_q <= 1'b1;
                            state_q      <= EXEC;
                        end
                    end
                end
                FETCH_ARG: begin
                    mem_rd_q <= 1'b1;
                    cnt_q    <= 2'd0;
                    state_q  <= WAIT_ARG;
                end
                WAIT_ARG: begin
                    if (!data_ready_s) begin
                        cnt_q <= cnt_q + 2'd1;
                    end else begin
                        jmp_q        <= memData;
                        exec_start_q <= 1'b1;
                        state_q      <= EXEC;
                    end
                end
                // execDone arriving alongside execStart is deliberately dropped here.
                EXEC: begin
                    state_q <= WAIT_EX;
                end
                WAIT_EX: begin
                    if (execDone) begin
                        wpc_q    <= 1'b1;
                        branch_q <= is_jump(ir_q);
                        ijump_q  <= is_ijump(ir_q);
                        state_q  <= FETCH_OP;
                    end else begin
                        state_q <= WAIT_EX;
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= FETCH_OP;
                end
            endcase
        end
    end

    assign memRd     = mem_rd_q;
    assign IR        = ir_q;
    assign jmpAddr   = jmp_q;
    assign execStart = exec_start_q;
    assign wPC       = wpc_q;
    assign branch    = branch_q;
    assign ijump     = ijump_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: instance A (MEM_LAT=1) and B (MEM_LAT=2) each with a RAM and PC model.
module tb_ifetch_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, execDone_a = 1'b0;
    logic [7:0] memData_a, IR_a, jmpAddr_a;
    logic       memRd_a, execStart_a, wPC_a, branch_a, ijump_a, halted_a, illegal_a;
    logic       rst_b = 1'b1, execDone_b = 1'b0;
    logic [7:0] memData_b, IR_b, jmpAddr_b;
    logic       memRd_b, execStart_b, wPC_b, branch_b, ijump_b, halted_b, illegal_b;

    logic [7:0] mem [256];
    logic [7:0] pc_a, pc_b, s1_b;
    logic       s1v_b;
    logic       alu_flag = 1'b0;

    typedef struct packed {
        logic [7:0] ir;
        logic [7:0] jmp;
        logic       br;
        logic       ij;
    } exp_t;
    exp_t sb[$];

    int total = 0, bad = 0;
    int n_rd_a = 0, n_wpc_a = 0, n_es_a = 0, n_br_a = 0, n_ovl_a = 0, n_ovl_b = 0;

    ifetch_ctrl #(.MEM_LAT(1), .HALT_OPC(8'hF0)) dut_a (
        .clk(clk), .rst(rst_a), .memData(memData_a), .execDone(execDone_a),
        .memRd(memRd_a), .IR(IR_a), .jmpAddr(jmpAddr_a), .execStart(execStart_a),
        .wPC(wPC_a), .branch(branch_a), .ijump(ijump_a), .halted(halted_a), .illegal(illegal_a)
    );

    ifetch_ctrl #(.MEM_LAT(2), .HALT_OPC(8'hF0)) dut_b (
        .clk(clk), .rst(rst_b), .memData(memData_b), .execDone(execDone_b),
        .memRd(memRd_b), .IR(IR_b), .jmpAddr(jmpAddr_b), .execStart(execStart_b),
        .wPC(wPC_b), .branch(branch_b), .ijump(ijump_b), .halted(halted_b), .illegal(illegal_b)
    );

    // PC registers and program RAM; 8'hEE marks cycles with no valid read data.
    always @(posedge clk) begin
        if (rst_a) pc_a <= 8'h00;
        else if (wPC_a) pc_a <= (branch_a && (ijump_a || alu_flag)) ? jmpAddr_a : pc_a + 8'h01;
        memData_a <= memRd_a ? mem[pc_a] : 8'hEE;
        if (rst_b) pc_b <= 8'h00;
        else if (wPC_b) pc_b <= (branch_b && (ijump_b || alu_flag)) ? jmpAddr_b : pc_b + 8'h01;
        s1v_b     <= memRd_b;
        s1_b      <= mem[pc_b];
        memData_b <= s1v_b ? s1_b : 8'hEE;
    end

    // Strobe activity counters, including overlapping or unqualified strobes.
    always @(negedge clk) begin
        if (memRd_a === 1'b1) n_rd_a++;
        if (wPC_a === 1'b1) n_wpc_a++;
        if (execStart_a === 1'b1) n_es_a++;
        if (branch_a === 1'b1) n_br_a++;
        if ((int'(memRd_a) + int'(wPC_a) + int'(execStart_a)) > 1 ||
            ((branch_a || ijump_a) && !wPC_a)) n_ovl_a++;
        if ((int'(memRd_b) + int'(wPC_b) + int'(execStart_b)) > 1 ||
            ((branch_b || ijump_b) && !wPC_b)) n_ovl_b++;
    end

    task automatic reset_dut(input bit b);
        @(negedge clk);
        if (b) rst_b = 1'b1; else rst_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if (b) begin rst_b = 1'b0; execDone_b = 1'b0; end
        else begin rst_a = 1'b0; execDone_a = 1'b0; end
        #1;
    endtask

    // Returns the cycle (counted from the call) where execStart shows, or 0 on timeout.
    task automatic wait_start(input bit b, input int budget, output int cyc);
        cyc = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if ((b ? execStart_b : execStart_a) === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic pulse_done(input bit b);
        @(negedge clk);
        if (b) execDone_b = 1'b1; else execDone_a = 1'b1;
        @(negedge clk);
        if (b) execDone_b = 1'b0; else execDone_a = 1'b0;
    endtask

    task automatic test_reset;
        rst_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({memRd_a, IR_a, jmpAddr_a, wPC_a, execStart_a, halted_a, illegal_a} !== 21'd0) begin
            bad++;
            $display("FAIL reset_values: got rd=%b ir=%h jmp=%h wpc=%b es=%b h=%b il=%b want all 0",
                     memRd_a, IR_a, jmpAddr_a, wPC_a, execStart_a, halted_a, illegal_a);
        end
        rst_a = 1'b0;
        @(negedge clk);
        total++;
        if ({memRd_a, IR_a, wPC_a, halted_a} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL first_fetch: got rd=%b ir=%h wpc=%b h=%b want rd=1 ir=00 wpc=0 h=0",
                     memRd_a, IR_a, wPC_a, halted_a);
        end
    endtask

    task automatic test_opcode_only;
        int cyc, w0;
        exp_t e;
        mem[8'h00] = 8'h00;
        sb.push_back('{ir: 8'h00, jmp: 8'h00, br: 1'b0, ij: 1'b0});
        reset_dut(1'b0);
        w0 = n_wpc_a;
        wait_start(1'b0, 20, cyc);
        e = sb.pop_front();
        total++;
        if (cyc !== 3) begin
            bad++;
            $display("FAIL inbox_latency: got %0d want 3", cyc);
        end
        total++;
        if ({IR_a, jmpAddr_a} !== {e.ir, e.jmp}) begin
            bad++;
            $display("FAIL inbox_regs: got %h/%h want %h/%h", IR_a, jmpAddr_a, e.ir, e.jmp);
        end
        pulse_done(1'b0);
        total++;
        if ({wPC_a, branch_a, ijump_a} !== {1'b1, e.br, e.ij}) begin
            bad++;
            $display("FAIL inbox_wpc: got %b%b%b want 1%b%b", wPC_a, branch_a, ijump_a, e.br, e.ij);
        end
        #1;
        total++;
        if (n_wpc_a - w0 !== 1) begin
            bad++;
            $display("FAIL inbox_wpc_count: got %0d want 1", n_wpc_a - w0);
        end
    endtask

    task automatic test_operand;
        int cyc, w0, b0;
        exp_t e;
        mem[8'h00] = 8'h28;
        mem[8'h01] = 8'h07;
        sb.push_back('{ir: 8'h28, jmp: 8'h07, br: 1'b0, ij: 1'b0});
        reset_dut(1'b0);
        w0 = n_wpc_a;
        b0 = n_br_a;
        wait_start(1'b0, 20, cyc);
        e = sb.pop_front();
        total++;
        if (cyc !== 6) begin
            bad++;
            $display("FAIL operand_latency: got %0d want 6", cyc);
        end
        total++;
        if ({IR_a, jmpAddr_a} !== {e.ir, e.jmp}) begin
            bad++;
            $display("FAIL operand_regs: got %h/%h want %h/%h", IR_a, jmpAddr_a, e.ir, e.jmp);
        end
        execDone_a = 1'b1;
        @(negedge clk);
        execDone_a = 1'b0;
        total++;
        if (wPC_a !== 1'b0) begin
            bad++;
            $display("FAIL done_with_start: got wpc=%b want 0", wPC_a);
        end
        pulse_done(1'b0);
        total++;
        if ({wPC_a, branch_a, ijump_a} !== {1'b1, e.br, e.ij}) begin
            bad++;
            $display("FAIL operand_wpc: got %b%b%b want 1%b%b", wPC_a, branch_a, ijump_a, e.br, e.ij);
        end
        #1;
        total++;
        if ({n_wpc_a - w0, n_br_a - b0} !== {32'd2, 32'd0}) begin
            bad++;
            $display("FAIL operand_pulses: got wpc=%0d br=%0d want wpc=2 br=0",
                     n_wpc_a - w0, n_br_a - b0);
        end
    endtask

    task automatic test_jump;
        int cyc;
        exp_t e;
        mem[8'h00] = 8'h80; mem[8'h01] = 8'h30;
        mem[8'h30] = 8'h90; mem[8'h31] = 8'h40; mem[8'h32] = 8'h00;
        alu_flag = 1'b0;
        sb.push_back('{ir: 8'h80, jmp: 8'h30, br: 1'b1, ij: 1'b1});
        sb.push_back('{ir: 8'h90, jmp: 8'h40, br: 1'b1, ij: 1'b0});
        sb.push_back('{ir: 8'h00, jmp: 8'h40, br: 1'b0, ij: 1'b0});
        reset_dut(1'b0);
        for (int k = 0; k < 3; k++) begin
            wait_start(1'b0, 30, cyc);
            e = sb.pop_front();
            total++;
            if (cyc == 0 || {IR_a, jmpAddr_a} !== {e.ir, e.jmp}) begin
                bad++;
                $display("FAIL jump_regs[%0d]: got cyc=%0d %h/%h want %h/%h",
                         k, cyc, IR_a, jmpAddr_a, e.ir, e.jmp);
            end
            pulse_done(1'b0);
            total++;
            if ({wPC_a, branch_a, ijump_a} !== {1'b1, e.br, e.ij}) begin
                bad++;
                $display("FAIL jump_wpc[%0d]: got %b%b%b want 1%b%b",
                         k, wPC_a, branch_a, ijump_a, e.br, e.ij);
            end
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        exp_t e;
        mem[8'h00] = 8'h10; mem[8'h01] = 8'h33; mem[8'h02] = 8'h12;
        mem[8'h03] = 8'hA0; mem[8'h04] = 8'h08;
        mem[8'h08] = 8'h61; mem[8'h09] = 8'h44; mem[8'h0A] = 8'h00;
        alu_flag = 1'b1;
        sb.push_back('{ir: 8'h10, jmp: 8'h00, br: 1'b0, ij: 1'b0});
        sb.push_back('{ir: 8'h33, jmp: 8'h12, br: 1'b0, ij: 1'b0});
        sb.push_back('{ir: 8'hA0, jmp: 8'h08, br: 1'b1, ij: 1'b0});
        sb.push_back('{ir: 8'h61, jmp: 8'h44, br: 1'b0, ij: 1'b0});
        sb.push_back('{ir: 8'h00, jmp: 8'h44, br: 1'b0, ij: 1'b0});
        reset_dut(1'b0);
        for (int k = 0; k < 5; k++) begin
            wait_start(1'b0, 30, cyc);
            e = sb.pop_front();
            total++;
            if (cyc == 0 || {IR_a, jmpAddr_a} !== {e.ir, e.jmp}) begin
                bad++;
                $display("FAIL b2b_regs[%0d]: got cyc=%0d %h/%h want %h/%h",
                         k, cyc, IR_a, jmpAddr_a, e.ir, e.jmp);
            end
            pulse_done(1'b0);
            total++;
            if ({wPC_a, branch_a, ijump_a} !== {1'b1, e.br, e.ij}) begin
                bad++;
                $display("FAIL b2b_wpc[%0d]: got %b%b%b want 1%b%b",
                         k, wPC_a, branch_a, ijump_a, e.br, e.ij);
            end
        end
        alu_flag = 1'b0;
        #1;
        total++;
        if (n_ovl_a !== 0) begin
            bad++;
            $display("FAIL strobe_overlap_a: got %0d want 0", n_ovl_a);
        end
    endtask

    task automatic test_halt;
        int r0, e0, w0;
        mem[8'h00] = 8'hF0;
        reset_dut(1'b0);
        r0 = n_rd_a; e0 = n_es_a; w0 = n_wpc_a;
        repeat (3) @(negedge clk);
        total++;
        if ({halted_a, illegal_a} !== 2'b10) begin
            bad++;
            $display("FAIL halt_state: got h=%b il=%b want h=1 il=0", halted_a, illegal_a);
        end
        pulse_done(1'b0);
        repeat (8) @(negedge clk);
        #1;
        total++;
        if ({n_rd_a - r0, n_es_a - e0, n_wpc_a - w0} !== {32'd1, 32'd0, 32'd0} || halted_a !== 1'b1) begin
            bad++;
            $display("FAIL halt_quiet: got rd=%0d es=%0d wpc=%0d h=%b want rd=1 es=0 wpc=0 h=1",
                     n_rd_a - r0, n_es_a - e0, n_wpc_a - w0, halted_a);
        end
    endtask

    task automatic test_illegal;
        int r0, e0, w0, b0, cyc;
        exp_t e;
        mem[8'h00] = 8'hB0;
        mem[8'h01] = 8'h00;
`ifdef ILLEGAL_TRAP_EN
        reset_dut(1'b0);
        r0 = n_rd_a; e0 = n_es_a; w0 = n_wpc_a; b0 = n_br_a;
        repeat (3) @(negedge clk);
        total++;
        if ({halted_a, illegal_a} !== 2'b11) begin
            bad++;
            $display("FAIL trap_state: got h=%b il=%b want h=1 il=1", halted_a, illegal_a);
        end
        repeat (6) @(negedge clk);
        #1;
        total++;
        if ({n_rd_a - r0, n_es_a - e0, n_wpc_a - w0} !== {32'd1, 32'd0, 32'd0}) begin
            bad++;
            $display("FAIL trap_quiet: got rd=%0d es=%0d wpc=%0d want rd=1 es=0 wpc=0",
                     n_rd_a - r0, n_es_a - e0, n_wpc_a - w0);
        end
        cyc = b0;
        e = '0;
`else
        sb.push_back('{ir: 8'h00, jmp: 8'h00, br: 1'b0, ij: 1'b0});
        reset_dut(1'b0);
        r0 = n_rd_a; e0 = n_es_a; w0 = n_wpc_a; b0 = n_br_a;
        wait_start(1'b0, 20, cyc);
        e = sb.pop_front();
        total++;
        if (cyc !== 6 || {IR_a, jmpAddr_a} !== {e.ir, e.jmp}) begin
            bad++;
            $display("FAIL nop_refetch: got cyc=%0d %h/%h want cyc=6 %h/%h",
                     cyc, IR_a, jmpAddr_a, e.ir, e.jmp);
        end
        #1;
        total++;
        if ({n_wpc_a - w0, n_br_a - b0, n_es_a - e0, n_rd_a - r0} !== {32'd1, 32'd0, 32'd1, 32'd2} ||
            {halted_a, illegal_a} !== 2'b00) begin
            bad++;
            $display("FAIL nop_pulses: got wpc=%0d br=%0d es=%0d rd=%0d h=%b il=%b want 1 0 1 2 0 0",
                     n_wpc_a - w0, n_br_a - b0, n_es_a - e0, n_rd_a - r0, halted_a, illegal_a);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int cyc;
        exp_t e;
        rst_a = 1'b1;
        mem[8'h00] = 8'h28;
        mem[8'h01] = 8'h07;
        sb.push_back('{ir: 8'h28, jmp: 8'h07, br: 1'b0, ij: 1'b0});
        reset_dut(1'b1);
        wait_start(1'b1, 30, cyc);
        e = sb.pop_front();
        total++;
        if (cyc !== 8 || {IR_b, jmpAddr_b} !== {e.ir, e.jmp}) begin
            bad++;
            $display("FAIL lat2_operand: got cyc=%0d %h/%h want cyc=8 %h/%h",
                     cyc, IR_b, jmpAddr_b, e.ir, e.jmp);
        end
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        total++;
        if ({IR_b, jmpAddr_b, wPC_b, execStart_b, memRd_b, halted_b} !== 20'd0) begin
            bad++;
            $display("FAIL rst_in_wait_ex: got ir=%h jmp=%h wpc=%b es=%b rd=%b h=%b want all 0",
                     IR_b, jmpAddr_b, wPC_b, execStart_b, memRd_b, halted_b);
        end
        rst_b = 1'b0;
        execDone_b = 1'b1;
        @(negedge clk);
        execDone_b = 1'b0;
        total++;
        if ({wPC_b, memRd_b} !== 2'b01) begin
            bad++;
            $display("FAIL late_done: got wpc=%b rd=%b want wpc=0 rd=1", wPC_b, memRd_b);
        end
        repeat (5) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        total++;
        if ({IR_b, jmpAddr_b, memRd_b, execStart_b} !== 18'd0) begin
            bad++;
            $display("FAIL rst_in_wait_arg: got ir=%h jmp=%h rd=%b es=%b want all 0",
                     IR_b, jmpAddr_b, memRd_b, execStart_b);
        end
        rst_b = 1'b0;
        #1;
        sb.push_back('{ir: 8'h28, jmp: 8'h07, br: 1'b0, ij: 1'b0});
        wait_start(1'b1, 30, cyc);
        e = sb.pop_front();
        total++;
        if (cyc !== 8 || {IR_b, jmpAddr_b} !== {e.ir, e.jmp}) begin
            bad++;
            $display("FAIL refetch_after_rst: got cyc=%0d %h/%h want cyc=8 %h/%h",
                     cyc, IR_b, jmpAddr_b, e.ir, e.jmp);
        end
        pulse_done(1'b1);
        total++;
        if ({wPC_b, branch_b, ijump_b} !== {1'b1, e.br, e.ij}) begin
            bad++;
            $display("FAIL lat2_wpc: got %b%b%b want 1%b%b", wPC_b, branch_b, ijump_b, e.br, e.ij);
        end
        #1;
        total++;
        if (n_ovl_b !== 0) begin
            bad++;
            $display("FAIL strobe_overlap_b: got %0d want 0", n_ovl_b);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_opcode_only();
        test_operand();
        test_jump();
        test_back_to_back();
        test_halt();
        test_illegal();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
